// File: rtl/r2b_pkg.sv
// r2b_pkg: derived-size helpers, FIFO depth and sideband/strip-tag types shared by raster_to_blocks
package r2b_pkg;
  localparam int FIFO_DEPTH = 4;
  localparam int ROW_W = 16;
  typedef struct packed {
    logic sob;
    logic eob;
    logic sof;
    logic eof;
  } blk_side_t;
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic             sof;
  } strip_tag_t;
  function automatic int bpl(input int x_res, input int n);
    return x_res / n;
  endfunction
  function automatic int bpr(input int bs, input int n);
    return bs / n;
  endfunction
  function automatic int strip_beats(input int bs, input int x_res, input int n);
    return bs * (x_res / n);
  endfunction
  function automatic int nstrip(input int y_res, input int bs);
    return y_res / bs;
  endfunction
  function automatic int aw(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/r2b_skid_fifo.sv
// r2b_skid_fifo: 4-entry sync FIFO of data+sidebands; push/din/sin in, pop/dout/sout out, count for issue credit
module r2b_skid_fifo
  import r2b_pkg::*;
#(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  blk_side_t    sin,
  input  logic         pop,
  output logic [W-1:0] dout,
  output blk_side_t    sout,
  output logic [2:0]   count
);
  logic [W+3:0] mem [FIFO_DEPTH];
  logic [$clog2(FIFO_DEPTH)-1:0] wp, rp;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign {sout, dout} = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {sin, din};
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + 3'(push) - 3'(do_pop);
    end
  end
endmodule

// File: rtl/raster_to_blocks.sv
// raster_to_blocks: ping-pong strip buffer turning raster hdmi_* beats into valid/ready blk_* block beats with ovf_* status
module raster_to_blocks
  import r2b_pkg::*;
#(
  parameter int N          = 2,
  parameter int X_RES      = 2160,
  parameter int Y_RES      = 1200,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hdmi_v_sync,
  input  logic                hdmi_data_valid,
  input  logic signed [8*N-1:0] hdmi_data_y,
  input  logic signed [8*N-1:0] hdmi_data_cr,
  input  logic signed [8*N-1:0] hdmi_data_cb,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic signed [8*N-1:0] blk_data_y,
  output logic signed [8*N-1:0] blk_data_cr,
  output logic signed [8*N-1:0] blk_data_cb,
  output logic                blk_sob,
  output logic                blk_eob,
  output logic                blk_sof,
  output logic                blk_eof,
  output logic                ovf_pulse,
  output logic                ovf_sticky,
  input  logic                ovf_clr
);
  localparam int BPL = bpl(X_RES, N);
  localparam int BPR = bpr(BLOCK_SIZE, N);
  localparam int STRIP = strip_beats(BLOCK_SIZE, X_RES, N);
  localparam int NSTRIP = nstrip(Y_RES, BLOCK_SIZE);
  localparam int NBLK = X_RES / BLOCK_SIZE;
  localparam int AW = aw(STRIP);
  localparam int RW = aw(NSTRIP);
  localparam int EW = aw(BPR);
  localparam int LW = aw(BLOCK_SIZE);
  localparam int KW = aw(NBLK);
  localparam int DW = 24 * N;
  typedef enum logic {IDLE, READ} state_t;
  state_t state;
  logic [DW-1:0] mem [2*STRIP];
  logic [DW-1:0] rd_q, fifo_data;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [RW-1:0] strip_row;
  logic [EW-1:0] elem;
  logic [LW-1:0] line;
  logic [KW-1:0] blk;
  logic [1:0] full;
  logic [2:0] count;
  strip_tag_t tag [2];
  blk_side_t side, side_q, fifo_side;
  logic wr_sel, rd_sel, sof_pending, discard, drop, wr_last, issue, inflight;
  logic e_last, l_last, b_last, sob;
  assign wr_last = hdmi_data_valid && wr_addr == AW'(STRIP - 1);
  assign drop = wr_addr == '0 ? full[wr_sel] : discard;
  assign e_last = elem == EW'(BPR - 1);
  assign l_last = line == LW'(BLOCK_SIZE - 1);
  assign b_last = blk == KW'(NBLK - 1);
  assign rd_addr = AW'(elem) + AW'(line) * AW'(BPL) + AW'(blk) * AW'(BPR);
  assign issue = state == READ && count + 3'(inflight) < 3'(FIFO_DEPTH);
  assign sob = elem == '0 && line == '0;
  assign side = '{sob: sob, eob: e_last && l_last, sof: sob && blk == '0 && tag[rd_sel].sof,
                  eof: e_last && l_last && b_last && tag[rd_sel].row == ROW_W'(NSTRIP - 1)};
  assign blk_valid = count != '0;
  assign {blk_data_cb, blk_data_cr, blk_data_y} = blk_valid ? fifo_data : '0;
  assign {blk_sob, blk_eob, blk_sof, blk_eof} = blk_valid ? fifo_side : '0;
  always_ff @(posedge clk) begin
    if (hdmi_data_valid && !drop) mem[{wr_sel, wr_addr}] <= {hdmi_data_cb, hdmi_data_cr, hdmi_data_y};
    rd_q <= mem[{rd_sel, rd_addr}];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      wr_sel <= 1'b0;
      strip_row <= '0;
      sof_pending <= 1'b1;
      discard <= 1'b0;
      full <= '0;
      tag <= '{default: '0};
      ovf_pulse <= 1'b0;
      ovf_sticky <= 1'b0;
      state <= IDLE;
      rd_sel <= 1'b0;
      elem <= '0;
      line <= '0;
      blk <= '0;
      inflight <= 1'b0;
      side_q <= '0;
    end else begin
      ovf_pulse <= 1'b0;
      inflight <= issue;
      if (ovf_clr) ovf_sticky <= 1'b0;
      if (hdmi_data_valid) begin
        discard <= drop;
        wr_addr <= wr_last ? '0 : wr_addr + AW'(1);
      end
      if (wr_last) begin
        strip_row <= strip_row == RW'(NSTRIP - 1) ? '0 : strip_row + RW'(1);
        if (drop) begin
          ovf_pulse <= 1'b1;
          ovf_sticky <= 1'b1;
        end else begin
          full[wr_sel] <= 1'b1;
          tag[wr_sel] <= '{row: ROW_W'(strip_row), sof: sof_pending};
          wr_sel <= ~wr_sel;
          sof_pending <= 1'b0;
        end
      end
      if (hdmi_v_sync) begin
        wr_addr <= '0;
        strip_row <= '0;
        sof_pending <= 1'b1;
      end
      if (state == IDLE) state <= full[rd_sel] ? READ : IDLE;
      else if (issue) begin
        side_q <= side;
        elem <= e_last ? '0 : elem + EW'(1);
        if (e_last) line <= l_last ? '0 : line + LW'(1);
        if (e_last && l_last) blk <= b_last ? '0 : blk + KW'(1);
        if (e_last && l_last && b_last) begin
          full[rd_sel] <= 1'b0;
          rd_sel <= ~rd_sel;
          state <= full[~rd_sel] ? READ : IDLE;
        end
      end
    end
  end
  r2b_skid_fifo #(.W(DW)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (rd_q),
    .sin  (side_q),
    .pop  (blk_ready),
    .dout (fifo_data),
    .sout (fifo_side),
    .count(count)
  );
endmodule
